sample_feeder: RTL and testbench

- Upstream stage of the perceptron neuron datapath.
- Holds the training set (x1, x2, t) in an internal sample memory, loaded by the host.
- Streams samples to the neuron controller one at a time over a valid/ready handshake, epoch after epoch.
- Stops when the controller reports convergence at an epoch boundary, or when the epoch limit is reached.

---
 rtl/neuron_pkg.sv | 18 +
 rtl/sample_mem.sv | 31 +++
 rtl/sample_feeder.sv | 213 +++++++++++++++++++++
 tb/tb_sample_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared widths, target encodings and feeder state type for the neuron datapath
package neuron_pkg;

    localparam int X_W     = 7;
    localparam int T_W     = 2;
    localparam int EPOCH_W = 16;

    localparam logic [T_W-1:0] T_POS = 2'b01;
    localparam logic [T_W-1:0] T_NEG = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/sample_mem.sv
// rtl/sample_mem.sv - training-set storage, synchronous write and 1-cycle registered read, no reset
module sample_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Read samples the array before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - streams stored (x1,x2,t) samples epoch by epoch; SAMPLE_FEEDER_PARITY_EN adds per-slot parity
module sample_feeder
    import neuron_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrEn,
    input  logic [ADDR_W-1:0]  wrAddr,
    input  logic [X_W-1:0]     wrX1,
    input  logic [X_W-1:0]     wrX2,
    input  logic [T_W-1:0]     wrT,
    input  logic [ADDR_W:0]    sampleCount,
    input  logic [EPOCH_W-1:0] epochMax,
    input  logic               start,
    input  logic               abort,
    input  logic               converged,
    input  logic               ready,
    output logic               valid,
    output logic [X_W-1:0]     x1,
    output logic [X_W-1:0]     x2,
    output logic [T_W-1:0]     t,
    output logic               last,
    output logic               busy,
    output logic               done,
    output logic [EPOCH_W-1:0] epochCnt,
`ifdef SAMPLE_FEEDER_PARITY_EN
    output logic               parityErr,
`endif
    output logic               timeout
);

    localparam int DATA_W = 2 * X_W + T_W;
`ifdef SAMPLE_FEEDER_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] NEFF_MAX = (ADDR_W + 1)'(DEPTH);

    feeder_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [X_W-1:0]     x1_q, x1_d;
    logic [X_W-1:0]     x2_q, x2_d;
    logic [T_W-1:0]     t_q, t_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               timeout_q, timeout_d;
`ifdef SAMPLE_FEEDER_PARITY_EN
    logic               perr_q, perr_d;
`endif

    logic [ADDR_W:0]    neff;
    logic               at_last;
    logic [EPOCH_W:0]   epoch_inc;
    logic               step;
    logic               parity_ok;
    logic               mem_wr_en;
    logic               mem_rd_en;
    logic [MEM_W-1:0]   mem_wr_data;
    logic [MEM_W-1:0]   mem_rd_data;
    logic [DATA_W-1:0]  rd_payload;

    assign neff      = (sampleCount > NEFF_MAX) ? NEFF_MAX : sampleCount;
    assign at_last   = ({1'b0, addr_q} == (neff - 1'b1));
    assign epoch_inc = {1'b0, epoch_q} + 1'b1;
    assign mem_wr_en = wrEn && (state_q == IDLE);

    assign rd_payload = mem_rd_data[DATA_W-1:0];
`ifdef SAMPLE_FEEDER_PARITY_EN
    assign mem_wr_data = {^{wrX1, wrX2, wrT}, wrX1, wrX2, wrT};
    assign parity_ok   = ~(^mem_rd_data);
`else
    assign mem_wr_data = {wrX1, wrX2, wrT};
    assign parity_ok   = 1'b1;
`endif

    // The read is launched on the edge that enters FETCH, so data is ready to register on leaving it.
    assign mem_rd_en = (state_d == FETCH);

    sample_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (MEM_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_wr_en),
        .wr_addr_i (wrAddr),
        .wr_data_i (mem_wr_data),
        .rd_en_i   (mem_rd_en),
        .rd_addr_i (addr_d),
        .rd_data_o (mem_rd_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        t_d       = t_q;
        epoch_d   = epoch_q;
        timeout_d = timeout_q;
`ifdef SAMPLE_FEEDER_PARITY_EN
        perr_d    = perr_q;
`endif
        step      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    epoch_d   = '0;
                    timeout_d = 1'b0;
                    addr_d    = '0;
`ifdef SAMPLE_FEEDER_PARITY_EN
                    perr_d    = 1'b0;
`endif
                    state_d   = (neff == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (parity_ok) begin
                    x1_d    = rd_payload[DATA_W-1 -: X_W];
                    x2_d    = rd_payload[T_W+X_W-1 -: X_W];
                    t_d     = rd_payload[T_W-1:0];
                    state_d = PRESENT;
                end else begin
                    // A corrupted slot is consumed silently, exactly like a handshake.
                    step = 1'b1;
`ifdef SAMPLE_FEEDER_PARITY_EN
                    perr_d = 1'b1;
`endif
                end
            end
            PRESENT: begin
                step = ready;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (step) begin
            if (!at_last) begin
                addr_d  = addr_q + 1'b1;
                state_d = FETCH;
            end else begin
                addr_d = '0;
                if (epoch_q != '1) begin
                    epoch_d = epoch_q + 1'b1;
                end
                if (converged) begin
                    state_d = DONE;
                end else if ((epochMax != '0) && (epoch_inc == {1'b0, epochMax})) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = FETCH;
                end
            end
        end

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            addr_d    = addr_q;
            epoch_d   = epoch_q;
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            t_q       <= '0;
            epoch_q   <= '0;
            timeout_q <= 1'b0;
`ifdef SAMPLE_FEEDER_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            t_q       <= t_d;
            epoch_q   <= epoch_d;
            timeout_q <= timeout_d;
`ifdef SAMPLE_FEEDER_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign valid    = (state_q == PRESENT);
    assign last     = valid && at_last;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign x1       = x1_q;
    assign x2       = x2_q;
    assign t        = t_q;
    assign epochCnt = epoch_q;
    assign timeout  = timeout_q;
`ifdef SAMPLE_FEEDER_PARITY_EN
    assign parityErr = perr_q;
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - randomized self-checking bench for sample_feeder against a sample-sequence model
module tb_sample_feeder;
    import neuron_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               wrEn;
    logic [ADDR_W-1:0]  wrAddr;
    logic [X_W-1:0]     wrX1, wrX2;
    logic [T_W-1:0]     wrT;
    logic [ADDR_W:0]    sampleCount;
    logic [EPOCH_W-1:0] epochMax;
    logic               start, abort, converged, ready;
    logic               valid, last, busy, done, timeout;
    logic [X_W-1:0]     x1, x2;
    logic [T_W-1:0]     t;
    logic [EPOCH_W-1:0] epochCnt;
`ifdef SAMPLE_FEEDER_PARITY_EN
    logic               parityErr;
`endif

    sample_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .wrX1        (wrX1),
        .wrX2        (wrX2),
        .wrT         (wrT),
        .sampleCount (sampleCount),
        .epochMax    (epochMax),
        .start       (start),
        .abort       (abort),
        .converged   (converged),
        .ready       (ready),
        .valid       (valid),
        .x1          (x1),
        .x2          (x2),
        .t           (t),
        .last        (last),
        .busy        (busy),
        .done        (done),
        .epochCnt    (epochCnt),
`ifdef SAMPLE_FEEDER_PARITY_EN
        .parityErr   (parityErr),
`endif
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [X_W-1:0] sx1 [DEPTH];
    logic [X_W-1:0] sx2 [DEPTH];
    logic [T_W-1:0] st  [DEPTH];
    bit             skip [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks begin and end just after a falling edge.
    task automatic write_slot(input int a, input bit randomize_it);
        logic [X_W-1:0] v1, v2;
        logic [T_W-1:0] vt;
        v1 = X_W'($urandom);
        v2 = X_W'($urandom);
        vt = ($urandom_range(0, 1) == 1) ? T_POS : T_NEG;
        if (!randomize_it) begin
            v1 = X_W'(a + 1);
            v2 = X_W'(a + 2);
        end
        wrEn = 1'b1; wrAddr = ADDR_W'(a); wrX1 = v1; wrX2 = v2; wrT = vt;
        sx1[a] = v1; sx2[a] = v2; st[a] = vt;
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < DEPTH; i++) write_slot(i, 1'b1);
    endtask

    // rmode: 0 ready always high, 1 random, 2 held low for the first 7 presented cycles
    task automatic run(input int n, input int emax, input int conv, input int rmode, input bit noise);
        int neff, n_ep, exp_to, hs, cyc, first_valid, lasts, stalls, idx, total;
        bit done_seen, stall;
        logic [X_W-1:0] px1, px2;
        logic [T_W-1:0] pt;
        logic           plast;
        int q[$];

        neff = (n > DEPTH) ? DEPTH : n;
        if (neff == 0) begin
            n_ep = 0; exp_to = 0;
        end else if (conv != 0 && (emax == 0 || conv <= emax)) begin
            n_ep = conv; exp_to = 0;
        end else begin
            n_ep = emax; exp_to = 1;
        end
        for (int e = 0; e < n_ep; e++)
            for (int i = 0; i < neff; i++)
                if (!skip[i]) q.push_back(i);
        total = q.size();

        sampleCount = (ADDR_W + 1)'(n);
        epochMax = EPOCH_W'(emax);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; cyc = 0; first_valid = -1; lasts = 0; stalls = 0;
        done_seen = 1'b0; stall = 1'b0;
        px1 = '0; px2 = '0; pt = '0; plast = 1'b0;

        while (!done_seen && cyc < 4000) begin
            cyc++;
            if (stall)
                check("hold", {valid, x1, x2, t, last}, {1'b1, px1, px2, pt, plast});
            if (valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_seen = 1'b1;
                check("busy_in_done", busy, 1);
            end
            case (rmode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: ready = (stalls < 7) ? 1'b0 : 1'b1;
            endcase
            converged = (conv != 0) && (lasts + 1 == conv);
            if (valid && ready) begin
                if (q.size() == 0) begin
                    check("extra_handshake", 1, 0);
                end else begin
                    idx = q.pop_front();
                    check("sample", {x1, x2, t, last},
                          {sx1[idx], sx2[idx], st[idx], 1'(idx == neff - 1)});
                end
                if (last) lasts++;
                hs++;
            end
            if (valid && !ready) stalls++;
            stall = valid && !ready;
            px1 = x1; px2 = x2; pt = t; plast = last;
            wrEn  = noise && !done_seen && ($urandom_range(0, 1) == 1);
            wrAddr = (ADDR_W)'($urandom);
            wrX1 = X_W'($urandom); wrX2 = X_W'($urandom); wrT = T_W'($urandom);
            start = noise && !done_seen && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        wrEn = 1'b0; start = 1'b0; converged = 1'b0; ready = 1'b0;

        check("done_seen", done_seen, 1);
        check("handshakes", hs, total);
        check("epochCnt", epochCnt, n_ep);
        check("timeout", timeout, exp_to);
        check("done_one_cycle", {done, busy}, 2'b00);
        if (neff == 0) begin
            check("no_valid_n0", first_valid, -1);
            check("done_latency_n0", cyc <= 2, 1);
        end else if (rmode == 0 && !skip[0]) begin
            check("first_valid", first_valid, 2);
        end
        if (rmode == 2) check("stall_cycles", stalls, 7);
    endtask

    initial begin
        int cnt, nn, em, cv;
        rst = 1'b0; wrEn = 1'b0; wrAddr = '0; wrX1 = '0; wrX2 = '0; wrT = '0;
        sampleCount = '0; epochMax = '0; start = 1'b0; abort = 1'b0;
        converged = 1'b0; ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) skip[i] = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {valid, busy, done, timeout, last, x1, x2, t, epochCnt}, '0);
`ifdef SAMPLE_FEEDER_PARITY_EN
        check("reset_parityErr", parityErr, 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        load_all();

        run(4, 0, 1, 0, 1'b0);
        run(3, 5, 0, 0, 1'b0);
        run(4, 0, 1, 2, 1'b0);
        run(0, 0, 1, 0, 1'b0);
        run(100, 0, 1, 1, 1'b0);
        run(4, 2, 0, 1, 1'b1);
        run(2, 2, 2, 0, 1'b0);
        write_slot(0, 1'b0);
        run(1, 1, 0, 0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            nn = $urandom_range(1, 8);
            em = $urandom_range(0, 3);
            cv = (em == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            run(nn, em, cv, 1, 1'b1);
        end

        // abort on the third presented sample
        sampleCount = 7'd4; epochMax = '0; ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 3; c++) begin
            if (valid) cnt++;
            if (cnt == 3) begin
                check("abort_slot2", {x1, x2, t}, {sx1[2], sx2[2], st[2]});
                abort = 1'b1; ready = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        check("abort_reached", cnt, 3);
        check("abort_next", {valid, busy, done}, 3'b000);
        check("abort_epoch_hold", epochCnt, 0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (done || busy) cnt++;
            @(negedge clk);
        end
        check("abort_no_done", cnt, 0);

        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_beats_start", busy, 0);

        // asynchronous reset in mid-run
        sampleCount = 7'd4; epochMax = '0; ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 13; c++) @(negedge clk);
        check("pre_reset_busy_epoch", {busy, 1'(epochCnt >= 1)}, 2'b11);
        #2 rst = 1'b0;
        #1 check("async_reset", {valid, busy, done, timeout, last, x1, x2, t, epochCnt}, '0);
        @(negedge clk);
        rst = 1'b1; ready = 1'b0;
        @(negedge clk);
        load_all();
        run(4, 0, 1, 0, 1'b0);

`ifdef SAMPLE_FEEDER_PARITY_EN
        dut.u_mem.mem_q[1][0] = ~dut.u_mem.mem_q[1][0];
        skip[1] = 1'b1;
        run(4, 0, 1, 0, 1'b0);
        check("parityErr_set", parityErr, 1);
        skip[1] = 1'b0;
        write_slot(1, 1'b1);
        run(4, 0, 1, 0, 1'b0);
        check("parityErr_cleared", parityErr, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
